bcd_sum_display: RTL

- Output stage directly downstream of the combinational 4-bit BCD adder.
- Captures the adder's sum digit and carry on a load strobe and holds the two-digit result (00..19).
- Drives a time-multiplexed two-digit 7-segment display: ones digit, plus tens digit showing "1" or blank.
- Flags invalid BCD sum digits (>9) and shows a dash for them.

---
 rtl/bcd_sum_display.sv | 89 ++++++++
 1 files changed

// File: rtl/bcd_sum_display.sv
// Holds the BCD adder's sum digit and carry on a load strobe and scans them onto
// a two-digit multiplexed 7-segment display. An invalid sum digit (>9) raises err
// and is shown as a dash.
module bcd_sum_display #(
   parameter int REFRESH_DIV = 50000,
   parameter bit ACTIVE_LOW  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] sum,
   input  logic       carry,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0] AN_POL  = ACTIVE_LOW ? 2'b11 : 2'b00;

   logic [3:0]    held_sum;
   logic          held_carry;
   logic [CW-1:0] cnt;
   logic          sel;        // 0 = ones digit, 1 = tens digit
   logic [6:0]    pattern;
   logic [1:0]    enable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_sum   <= 4'd0;
         held_carry <= 1'b0;
         err        <= 1'b0;
      end else if (load) begin
         held_sum   <= sum;
         held_carry <= carry;
         err        <= (sum > 4'd9);
      end
   end

   // Scan timing is independent of loads so the refresh rate never jitters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sel <= 1'b0;
      end else if (cnt == LAST) begin
         cnt <= '0;
         sel <= ~sel;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      pattern = 7'h00;
      enable  = 2'b01;
      if (sel) begin
         enable  = 2'b10;
         pattern = held_carry ? 7'h06 : 7'h00;
      end else begin
         case (held_sum)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
         endcase
      end
   end

   // seg and an share one register stage so the digit enable and its pattern switch together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= 7'h3F ^ SEG_POL;
         an  <= 2'b01 ^ AN_POL;
      end else begin
         seg <= pattern ^ SEG_POL;
         an  <= enable ^ AN_POL;
      end
   end

endmodule
